// File: rtl/cache_line_fill.sv
// Miss-handling engine: writes back a dirty victim, invalidates it, bursts the
// new line in from memory word by word, then commits the new tag.
//
// state  | meaning
// IDLE   | waiting for a miss pulse
// WB     | writing back dirty victim words to memory
// INVAL  | clearing the victim tag valid bit
// FILL   | reading new line words from memory into the data array
// COMMIT | writing the new tag as valid, pulsing done
module cache_line_fill #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int INDEX_W = 6,
    parameter int WORD_W  = 2,
    localparam int TAG_W  = ADDR_W - INDEX_W - WORD_W - 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               miss,
    input  logic [ADDR_W-1:0]  miss_addr,
    input  logic [1:0]         victim_way,
    input  logic               victim_dirty,
    input  logic [TAG_W-1:0]   victim_tag,
    output logic               busy,
    output logic               done,
    output logic               mem_req,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic               mem_ready,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic [1:0]         line_way,
    output logic [INDEX_W-1:0] line_set,
    output logic [WORD_W-1:0]  line_word,
    input  logic [DATA_W-1:0]  arr_rdata,
    output logic               fill_we,
    output logic [DATA_W-1:0]  fill_wdata,
    output logic               tag_we,
    output logic               tag_valid,
    output logic [TAG_W-1:0]   tag_wdata
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WB     = 3'd1;
    localparam logic [2:0] S_INVAL  = 3'd2;
    localparam logic [2:0] S_FILL   = 3'd3;
    localparam logic [2:0] S_COMMIT = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [WORD_W-1:0]  cnt_q, cnt_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [TAG_W-1:0]   vtag_q, vtag_d;
    logic [INDEX_W-1:0] set_q, set_d;
    logic [1:0]         way_q, way_d;
    logic               last_word;

    assign last_word = (cnt_q == {WORD_W{1'b1}});

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tag_d   = tag_q;
        vtag_d  = vtag_q;
        set_d   = set_q;
        way_d   = way_q;
        case (state_q)
            S_IDLE: begin
                if (miss) begin
                    tag_d   = miss_addr[ADDR_W-1 -: TAG_W];
                    set_d   = miss_addr[WORD_W+2 +: INDEX_W];
                    way_d   = victim_way;
                    vtag_d  = victim_tag;
                    cnt_d   = '0;
                    state_d = victim_dirty ? S_WB : S_INVAL;
                end
            end
            S_WB: begin
                if (mem_ready) begin
                    cnt_d = cnt_q + WORD_W'(1);
                    if (last_word) state_d = S_INVAL;
                end
            end
            S_INVAL: begin
                cnt_d   = '0;
                state_d = S_FILL;
            end
            S_FILL: begin
                if (mem_ready) begin
                    cnt_d = cnt_q + WORD_W'(1);
                    if (last_word) state_d = S_COMMIT;
                end
            end
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tag_q   <= '0;
            vtag_q  <= '0;
            set_q   <= '0;
            way_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
            vtag_q  <= vtag_d;
            set_q   <= set_d;
            way_q   <= way_d;
        end
    end

    // All outputs decode from registered state so a reset clears them at once.
    always_comb begin
        busy       = (state_q != S_IDLE);
        done       = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        line_way   = '0;
        line_set   = '0;
        line_word  = '0;
        fill_we    = 1'b0;
        fill_wdata = '0;
        tag_we     = 1'b0;
        tag_valid  = 1'b0;
        tag_wdata  = '0;
        if (busy) begin
            line_way = way_q;
            line_set = set_q;
        end
        case (state_q)
            S_WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {vtag_q, set_q, cnt_q, 2'b00};
                mem_wdata = arr_rdata;
                line_word = cnt_q;
            end
            S_INVAL: begin
                tag_we    = 1'b1;
                tag_wdata = tag_q;
            end
            S_FILL: begin
                mem_req    = 1'b1;
                mem_addr   = {tag_q, set_q, cnt_q, 2'b00};
                line_word  = cnt_q;
                fill_we    = mem_ready;
                fill_wdata = mem_ready ? mem_rdata : '0;
            end
            S_COMMIT: begin
                tag_we    = 1'b1;
                tag_valid = 1'b1;
                tag_wdata = tag_q;
                done      = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_line_fill.sv
// Bench for cache_line_fill: models the data array, tag array and memory,
// drives directed and randomized misses and compares against an abstract model.
module tb_cache_line_fill;

    logic        clk, reset, miss, victim_dirty, mem_ready;
    logic [31:0] miss_addr, mem_rdata, arr_rdata, mem_addr, mem_wdata, fill_wdata;
    logic [1:0]  victim_way, line_way, line_word;
    logic [21:0] victim_tag, tag_wdata;
    logic [5:0]  line_set;
    logic        busy, done, mem_req, mem_we, fill_we, tag_we, tag_valid;

    cache_line_fill dut (
        .clk(clk), .reset(reset), .miss(miss), .miss_addr(miss_addr),
        .victim_way(victim_way), .victim_dirty(victim_dirty), .victim_tag(victim_tag),
        .busy(busy), .done(done), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .line_way(line_way), .line_set(line_set),
        .line_word(line_word), .arr_rdata(arr_rdata), .fill_we(fill_we),
        .fill_wdata(fill_wdata), .tag_we(tag_we), .tag_valid(tag_valid),
        .tag_wdata(tag_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] darr [0:1023];
    logic        tv   [0:255];
    logic [21:0] tt   [0:255];
    logic        rdy  [0:299];

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign arr_rdata = darr[{line_way, line_set, line_word}];
    assign mem_rdata = memfn(mem_addr);

    logic [134:0] all_out;
    assign all_out = {busy, done, mem_req, mem_we, mem_addr, mem_wdata, line_way, line_set,
                      line_word, fill_we, fill_wdata, tag_we, tag_valid, tag_wdata};

    logic [31:0] ob_addr[$], ob_wdata[$], ob_fdata[$];
    logic        ob_we[$], ob_tval[$];
    logic [1:0]  ob_fword[$];
    logic [21:0] ob_ttag[$];
    int          ob_tcyc[$];
    int          done_cnt, done_cyc, idle_cyc, line_bad, hold_bad, overlap;

    // Cycle in which done is expected when the miss is sampled in cycle 0.
    function automatic int exp_done_cyc(input logic dirty, output int inval_c);
        int t = 1;
        int k = 0;
        if (dirty) begin
            while (k < 4 && t < 299) begin
                if (rdy[t]) k++;
                t++;
            end
        end
        inval_c = t;
        t++;
        k = 0;
        while (k < 4 && t < 299) begin
            if (rdy[t]) k++;
            t++;
        end
        return t;
    endfunction

    task automatic set_rdy(input int pct);
        for (int c = 0; c < 300; c++) rdy[c] = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
    endtask

    task automatic do_miss(input logic [31:0] addr, input logic [1:0] way, input logic dirty,
                           input logic [21:0] vtag, input int second_c);
        logic [31:0] pa, pd;
        logic        pwe, pstall;
        ob_addr.delete(); ob_wdata.delete(); ob_we.delete(); ob_fword.delete();
        ob_fdata.delete(); ob_tval.delete(); ob_ttag.delete(); ob_tcyc.delete();
        done_cnt = 0; done_cyc = -1; idle_cyc = -1; line_bad = 0; hold_bad = 0; overlap = 0;
        pstall = 0; pa = 0; pd = 0; pwe = 0;
        miss = 1; miss_addr = addr; victim_way = way; victim_dirty = dirty; victim_tag = vtag;
        mem_ready = rdy[0];
        for (int c = 0; c < 300; c++) begin
            if (c > 0) begin
                @(negedge clk);
                miss = (c == second_c);
                if (c == second_c) begin
                    miss_addr = ~addr; victim_way = ~way; victim_dirty = ~dirty; victim_tag = ~vtag;
                end
                mem_ready = rdy[c];
            end
            #1;
            if (c > 0 && !busy) begin
                idle_cyc = c;
                break;
            end
            if (busy && (line_way !== way || line_set !== addr[9:4])) line_bad++;
            if (pstall && (mem_req !== 1'b1 || mem_addr !== pa || mem_we !== pwe || mem_wdata !== pd))
                hold_bad++;
            pstall = mem_req && !mem_ready; pa = mem_addr; pwe = mem_we; pd = mem_wdata;
            if (mem_req && mem_ready) begin
                ob_addr.push_back(mem_addr); ob_we.push_back(mem_we); ob_wdata.push_back(mem_wdata);
            end
            if (fill_we) begin
                ob_fword.push_back(line_word); ob_fdata.push_back(fill_wdata);
                darr[{line_way, line_set, line_word}] = fill_wdata;
            end
            if (tag_we) begin
                ob_tval.push_back(tag_valid); ob_ttag.push_back(tag_wdata); ob_tcyc.push_back(c);
                tv[{line_way, line_set}] = tag_valid; tt[{line_way, line_set}] = tag_wdata;
            end
            if ((fill_we && tag_we) || (mem_req && tag_we)) overlap++;
            if (done) begin
                done_cnt++; done_cyc = c;
            end
        end
        miss = 0;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++; $display("FAIL reset_outputs: got %0h want 0", all_out);
        end
        @(negedge clk); reset = 1;
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++; $display("FAIL idle_outputs: got %0h want 0", all_out);
        end
    endtask

    task automatic test_clean_miss;
        int bad = 0;
        set_rdy(100);
        @(negedge clk);
        do_miss(32'h0000_1230, 2'd2, 1'b0, 22'h0, -1);
        checks++;
        if (ob_addr.size() !== 4 || ob_fword.size() !== 4) begin
            errors++; $display("FAIL clean_counts: got %0d/%0d want 4/4", ob_addr.size(), ob_fword.size());
        end else begin
            for (int i = 0; i < 4; i++)
                if (ob_addr[i] !== 32'h1230 + 32'(4*i) || ob_we[i] !== 1'b0 || ob_fword[i] !== 2'(i)
                    || ob_fdata[i] !== memfn(32'h1230 + 32'(4*i))) bad++;
            checks++;
            if (bad !== 0) begin
                errors++; $display("FAIL clean_fill_seq: got %0d bad words want 0", bad);
            end
        end
        checks++;
        if (ob_tcyc.size() !== 2 || ob_tcyc[0] !== 1 || ob_tval[0] !== 1'b0 || ob_tcyc[1] !== 6
            || ob_tval[1] !== 1'b1 || ob_ttag[1] !== 22'h4) begin
            errors++; $display("FAIL clean_tags: got %0d writes want inval c1 commit c6 tag 4", ob_tcyc.size());
        end
        checks++;
        if (done_cyc !== 6 || done_cnt !== 1 || idle_cyc !== 7) begin
            errors++; $display("FAIL clean_timing: got done c%0d x%0d idle c%0d want c6 x1 c7", done_cyc, done_cnt, idle_cyc);
        end
        checks++;
        if (overlap !== 0 || line_bad !== 0) begin
            errors++; $display("FAIL clean_ports: got overlap %0d line_bad %0d want 0", overlap, line_bad);
        end
    endtask

    task automatic test_dirty_miss;
        int bad = 0;
        set_rdy(100);
        for (int w = 0; w < 4; w++) darr[{2'd1, 6'h23, 2'(w)}] = 32'hA0 + 32'(w);
        @(negedge clk);
        do_miss({22'h77, 6'h23, 4'h0}, 2'd1, 1'b1, 22'h5, -1);
        checks++;
        if (ob_addr.size() !== 8) begin
            errors++; $display("FAIL dirty_count: got %0d want 8", ob_addr.size());
        end else begin
            for (int w = 0; w < 4; w++) begin
                if (ob_we[w] !== 1'b1 || ob_addr[w] !== {22'h5, 6'h23, 2'(w), 2'b00}
                    || ob_wdata[w] !== 32'hA0 + 32'(w)) bad++;
                if (ob_we[w+4] !== 1'b0 || ob_addr[w+4] !== {22'h77, 6'h23, 2'(w), 2'b00}) bad++;
            end
            checks++;
            if (bad !== 0) begin
                errors++; $display("FAIL dirty_seq: got %0d bad transfers want 0", bad);
            end
        end
        checks++;
        if (done_cyc !== 10 || ob_tcyc.size() !== 2 || ob_tcyc[0] !== 5) begin
            errors++; $display("FAIL dirty_timing: got done c%0d want c10 with inval c5", done_cyc);
        end
    endtask

    task automatic test_stalls;
        for (int c = 0; c < 300; c++) rdy[c] = (c < 2) ? 1'b1 : ((c - 2) % 3 == 2);
        @(negedge clk);
        do_miss(32'h0000_1230, 2'd0, 1'b0, 22'h0, -1);
        checks++;
        if (hold_bad !== 0) begin
            errors++; $display("FAIL stall_hold: got %0d unstable cycles want 0", hold_bad);
        end
        checks++;
        if (ob_fword.size() !== 4 || ob_fword[3] !== 2'd3) begin
            errors++; $display("FAIL stall_fills: got %0d want 4", ob_fword.size());
        end
        checks++;
        if (done_cyc !== 14) begin
            errors++; $display("FAIL stall_done: got c%0d want c14", done_cyc);
        end
    endtask

    task automatic test_miss_while_busy;
        set_rdy(100);
        @(negedge clk);
        do_miss(32'h0000_4560, 2'd0, 1'b0, 22'h0, 3);
        checks++;
        if (line_bad !== 0 || done_cnt !== 1 || done_cyc !== 6 || ob_ttag.size() !== 2
            || ob_ttag[1] !== 22'h11 || ob_addr.size() !== 4 || ob_addr[3] !== 32'h456C) begin
            errors++; $display("FAIL busy_miss_ignored: got line_bad %0d done c%0d want 0 c6", line_bad, done_cyc);
        end
        @(negedge clk);
        do_miss(32'h0001_2340, 2'd1, 1'b0, 22'h0, -1);
        checks++;
        if (done_cyc !== 6 || ob_ttag.size() !== 2 || ob_ttag[1] !== 22'h48 || line_bad !== 0) begin
            errors++; $display("FAIL busy_next_miss: got done c%0d want c6 tag 48", done_cyc);
        end
    endtask

    task automatic test_reset_mid_fill;
        int nf = 0;
        int writes = 0;
        set_rdy(100);
        tv[{2'd3, 6'h15}] = 1'b1;
        @(negedge clk);
        miss = 1; miss_addr = 32'h00AB_C150; victim_way = 2'd3; victim_dirty = 1'b0; mem_ready = 1;
        for (int c = 1; c < 40 && nf < 2; c++) begin
            @(negedge clk); miss = 0;
            #1;
            if (fill_we) nf++;
            if (tag_we) tv[{line_way, line_set}] = tag_valid;
        end
        @(negedge clk); reset = 0;
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++; $display("FAIL reset_mid_outputs: got %0h want 0", all_out);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            if (tag_we || fill_we || done) writes++;
        end
        @(negedge clk); reset = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            if (tag_we || fill_we || done || busy) writes++;
        end
        checks++;
        if (writes !== 0 || nf !== 2) begin
            errors++; $display("FAIL reset_mid_quiet: got %0d writes, %0d fills want 0, 2", writes, nf);
        end
        checks++;
        if (tv[{2'd3, 6'h15}] !== 1'b0) begin
            errors++; $display("FAIL reset_mid_invalid: got %0b want 0", tv[{2'd3, 6'h15}]);
        end
    endtask

    task automatic test_back_to_back;
        int first_idle;
        set_rdy(100);
        @(negedge clk);
        do_miss(32'h0000_0A00, 2'd2, 1'b0, 22'h0, -1);
        first_idle = idle_cyc;
        do_miss(32'h0003_3310, 2'd3, 1'b1, 22'h1F, -1);
        checks++;
        if (first_idle !== 7 || ob_tcyc.size() !== 2 || ob_tcyc[0] !== 5 || done_cyc !== 10) begin
            errors++; $display("FAIL back_to_back: got idle c%0d done c%0d want c7 c10", first_idle, done_cyc);
        end
    endtask

    task automatic test_random;
        for (int it = 0; it < 10; it++) begin
            logic [31:0] addr, ea[$], ed[$];
            logic        ew[$];
            logic [1:0]  way;
            logic        dirty;
            logic [5:0]  set;
            logic [21:0] tag, vtag;
            int          inval_c, exp_done, bad;
            addr = $urandom; way = 2'($urandom_range(0, 3)); dirty = 1'($urandom_range(0, 1));
            set = addr[9:4]; tag = addr[31:10]; vtag = tt[{way, set}];
            set_rdy(65);
            ea.delete(); ed.delete(); ew.delete();
            if (dirty)
                for (int w = 0; w < 4; w++) begin
                    ea.push_back({vtag, set, 2'(w), 2'b00}); ew.push_back(1'b1);
                    ed.push_back(darr[{way, set, 2'(w)}]);
                end
            for (int w = 0; w < 4; w++) begin
                ea.push_back({tag, set, 2'(w), 2'b00}); ew.push_back(1'b0);
                ed.push_back(memfn({tag, set, 2'(w), 2'b00}));
            end
            exp_done = exp_done_cyc(dirty, inval_c);
            @(negedge clk);
            do_miss(addr, way, dirty, vtag, -1);
            bad = 0;
            if (ob_addr.size() !== ea.size() || ob_fword.size() !== 4) bad++;
            else begin
                for (int i = 0; i < ea.size(); i++)
                    if (ob_addr[i] !== ea[i] || ob_we[i] !== ew[i] || (ew[i] && ob_wdata[i] !== ed[i])) bad++;
                for (int w = 0; w < 4; w++)
                    if (ob_fword[w] !== 2'(w) || ob_fdata[w] !== ed[ea.size() - 4 + w]) bad++;
            end
            checks++;
            if (bad !== 0) begin
                errors++; $display("FAIL rand_transfers[%0d]: got %0d bad want 0", it, bad);
            end
            checks++;
            if (done_cyc !== exp_done || done_cnt !== 1 || idle_cyc !== exp_done + 1 || ob_tcyc.size() !== 2
                || ob_tcyc[0] !== inval_c || ob_tval[0] !== 1'b0 || ob_ttag[0] !== tag) begin
                errors++; $display("FAIL rand_timing[%0d]: got done c%0d want c%0d", it, done_cyc, exp_done);
            end
            checks++;
            if (tv[{way, set}] !== 1'b1 || tt[{way, set}] !== tag || hold_bad !== 0 || overlap !== 0 || line_bad !== 0) begin
                errors++; $display("FAIL rand_commit[%0d]: got valid %0b tag %0h want 1 %0h", it, tv[{way, set}], tt[{way, set}], tag);
            end
        end
    endtask

    initial begin
        reset = 0; miss = 0; miss_addr = 0; victim_way = 0; victim_dirty = 0; victim_tag = 0; mem_ready = 0;
        for (int i = 0; i < 1024; i++) darr[i] = $urandom;
        for (int i = 0; i < 256; i++) begin
            tv[i] = 1'b1; tt[i] = 22'($urandom);
        end
        test_reset;
        test_clean_miss;
        test_dirty_miss;
        test_stalls;
        test_miss_while_busy;
        test_reset_mid_fill;
        test_back_to_back;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule
